// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector: matches the last PAT_W accepted bits against a
// runtime-loadable pattern with a per-bit don't-care mask. It supports
// overlapping and non-overlapping matches and keeps a saturating match counter.
module seq_pattern_detector #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 4'b1011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match_o,
    output logic             armed,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int FW = $clog2(PAT_W + 1);

    typedef enum logic {FILL, HUNT} state_t;

    state_t           state;
    // Only PAT_W-1 past bits are stored; the incoming bit completes the window.
    logic [PAT_W-2:0] hist;
    logic [FW-1:0]    fill;
    logic [PAT_W-1:0] pat_r;
    logic [PAT_W-1:0] mask_r;
    logic             ovl_r;

    logic             acc;
    logic [PAT_W-1:0] hist_n;
    logic [FW-1:0]    fill_n;
    logic             full_n;
    logic             hit;
    logic [CNT_W-1:0] cnt_inc;

    // Next-window computation and match decision for the bit on the inputs.
    always_comb begin
        acc     = en & in_valid & ~cfg_load;
        hist_n  = {hist, in_bit};
        fill_n  = (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
        full_n  = (fill_n == FW'(PAT_W));
        hit     = acc & full_n & (((hist_n ^ pat_r) & mask_r) == '0);
        cnt_inc = match_cnt + 1'b1;
    end

    // Window/FSM, configuration capture, match pulse and counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            hist      <= '0;
            fill      <= '0;
            pat_r     <= RST_PAT;
            mask_r    <= '1;
            ovl_r     <= 1'b1;
            match_o   <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            match_o <= hit;

            if (cfg_load) begin
                // A reload invalidates the current window; the bit in this
                // cycle is dropped because acc is low.
                pat_r  <= cfg_pattern;
                mask_r <= cfg_mask;
                ovl_r  <= cfg_overlap;
                fill   <= '0;
                state  <= FILL;
            end else if (acc) begin
                hist <= hist_n[PAT_W-2:0];
                if (hit && !ovl_r) begin
                    // Non-overlapping: the next match needs PAT_W fresh bits.
                    fill  <= '0;
                    state <= FILL;
                end else begin
                    fill <= fill_n;
                    if (full_n)
                        state <= HUNT;
                end
            end

            if (cnt_clr) begin
                match_cnt <= '0;
                cnt_sat   <= 1'b0;
            end else if (hit) begin
                if (&match_cnt) begin
                    cnt_sat <= 1'b1;
                end else begin
                    match_cnt <= cnt_inc;
                    if (&cnt_inc)
                        cnt_sat <= 1'b1;
                end
            end
        end
    end

    assign armed = (state == HUNT);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed testbench for seq_pattern_detector. Three instances share the
// stimulus: the default 4-bit detector, a 2-bit-counter variant for the
// saturation checks, and a PAT_W=2 variant that mirrors the legacy run detector.
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       rst_n, en, in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
    logic [3:0] cfg_pattern, cfg_mask;
    logic [1:0] pat2, mask2;

    logic       match_o, armed, cnt_sat;
    logic [7:0] match_cnt;
    logic       s_match, s_armed, s_sat;
    logic [1:0] s_cnt;
    logic       l_match, l_armed, l_sat;
    logic [7:0] l_cnt;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_W(4), .CNT_W(8), .RST_PAT(4'b1011)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match_o(match_o), .armed(armed), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_pattern_detector #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b1011)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match_o(s_match), .armed(s_armed), .match_cnt(s_cnt), .cnt_sat(s_sat)
    );

    seq_pattern_detector #(.PAT_W(2), .CNT_W(8), .RST_PAT(2'b11)) u_leg (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(pat2), .cfg_mask(mask2),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match_o(l_match), .armed(l_armed), .match_cnt(l_cnt), .cnt_sat(l_sat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [3:0] p, input logic [3:0] m, input logic o);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_overlap = o;
        cnt_clr     = 1'b1;
        tick();
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    initial begin
        logic [6:0] stream;
        logic [6:0] exp_m;
        logic [6:0] exp_a;

        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
        cfg_load = 1'b0; cfg_overlap = 1'b1; cnt_clr = 1'b0;
        cfg_pattern = 4'b0000; cfg_mask = 4'b1111;
        pat2 = 2'b11; mask2 = 2'b11;

        // Reset state
        do_reset();
        chk("rst_match", match_o, 0);
        chk("rst_armed", armed, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_sat", cnt_sat, 0);

        // Overlap with the reset pattern 1011: stream 1,0,1,1,0,1,1 (index 6 first)
        stream = 7'b1011011;
        exp_m  = 7'b0001001;
        exp_a  = 7'b0001111;
        for (int i = 6; i >= 0; i--) begin
            send(stream[i]);
            chk($sformatf("ovl_match_b%0d", 7 - i), match_o, exp_m[i]);
            chk($sformatf("ovl_armed_b%0d", 7 - i), armed, exp_a[i]);
        end
        chk("ovl_cnt", match_cnt, 2);
        idle(1);
        chk("ovl_pulse_end", match_o, 0);

        // Non-overlap: single hit, window flushed so armed stays low
        load(4'b1011, 4'b1111, 1'b0);
        chk("novl_load_armed", armed, 0);
        chk("novl_load_cnt", match_cnt, 0);
        exp_m = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            send(stream[i]);
            chk($sformatf("novl_match_b%0d", 7 - i), match_o, exp_m[i]);
            chk($sformatf("novl_armed_b%0d", 7 - i), armed, 0);
        end
        chk("novl_cnt", match_cnt, 1);

        // Mask 1001 on pattern 1001 with valid gaps and en=0 periods
        load(4'b1001, 4'b1001, 1'b1);
        send(1'b1);
        send(1'b1);
        idle(2);
        chk("gap_match", match_o, 0);
        en = 1'b0;
        in_valid = 1'b1; in_bit = 1'b0;
        idle(2);
        in_valid = 1'b0; en = 1'b1;
        chk("en0_match", match_o, 0);
        chk("en0_armed", armed, 0);
        send(1'b1);
        chk("mask_b3_match", match_o, 0);
        chk("mask_b3_armed", armed, 0);
        send(1'b1);
        chk("mask_b4_match", match_o, 1);
        chk("mask_cnt", match_cnt, 1);

        // Reload mid-window: bit in the load cycle is dropped
        load(4'b1011, 4'b1111, 1'b1);
        send(1'b1); send(1'b0); send(1'b1);
        in_valid = 1'b1; in_bit = 1'b0;
        load(4'b0000, 4'b1111, 1'b1);
        in_valid = 1'b0;
        chk("reload_match", match_o, 0);
        chk("reload_armed", armed, 0);
        for (int i = 1; i <= 3; i++) begin
            send(1'b0);
            chk($sformatf("reload_z%0d", i), match_o, 0);
        end
        send(1'b0);
        chk("reload_z4", match_o, 1);
        chk("reload_z4_armed", armed, 1);

        // Reset mid-stream restores RST_PAT and discards the partial window
        send(1'b1); send(1'b0);
        do_reset();
        chk("mrst_match", match_o, 0);
        chk("mrst_armed", armed, 0);
        chk("mrst_cnt", match_cnt, 0);
        chk("mrst_sat", cnt_sat, 0);
        stream[3:0] = 4'b1011;
        exp_m[3:0]  = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            send(stream[i]);
            chk($sformatf("mrst_match_b%0d", 4 - i), match_o, exp_m[i]);
        end

        // Saturation on the 2-bit counter instance with mask 0000
        do_reset();
        load(4'b0000, 4'b0000, 1'b1);
        for (int i = 1; i <= 3; i++) send(1'b1);
        chk("sat_fill_cnt", s_cnt, 0);
        chk("sat_fill_match", s_match, 0);
        send(1'b0); chk("sat_cnt1", s_cnt, 1); chk("sat_match", s_match, 1);
        send(1'b1); chk("sat_cnt2", s_cnt, 2); chk("sat_flag_early", s_sat, 0);
        send(1'b0); chk("sat_cnt3", s_cnt, 3);
        send(1'b1); chk("sat_cnt3_hold", s_cnt, 3); chk("sat_flag", s_sat, 1);
        cnt_clr = 1'b1;
        send(1'b1);
        cnt_clr = 1'b0;
        chk("sat_clr_cnt", s_cnt, 0);
        chk("sat_clr_flag", s_sat, 0);
        chk("sat_clr_match", s_match, 1);

        // Legacy 2-bit run detector: stream 0,1,1,1,1,0,1
        do_reset();
        stream = 7'b0111101;
        exp_m  = 7'b0011100;
        for (int i = 6; i >= 0; i--) begin
            send(stream[i]);
            chk($sformatf("leg_match_b%0d", 7 - i), l_match, exp_m[i]);
        end
        chk("leg_cnt", l_cnt, 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
